syn_fifo: RTL and testbench
===========================

Name: syn_fifo

Overview:
- Bit-serial digital modulator front end: an 8-deep, 1-bit synchronous FIFO that buffers payload bits.
- On a read request it pops one bit and emits one carrier symbol of 16 signed 16-bit samples on data_pt.
- The modulation scheme is selected by SELMod. send_in pulses when a symbol completes.
- Sits between the bit source and the DAC/sample sink.

Parameters:
- DEPTH, 8, FIFO depth in bits (power of 2, at least 2).
- DATA_W, 16, sample width; two's complement.
- SAMPLES, 16, samples per symbol; fixed to the sine LUT length.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SELMod  in  2  modulation select: 00 ASK, 01 FSK, 10 BPSK, 11 reserved.
- wEN  in  1  write enable for dIn.
- rEN  in  1  level read request: pop one bit and start a symbol.
- dIn  in  1  payload bit to write.
- bFull  out  1  FIFO holds DEPTH bits.
- bEmpty  out  1  FIFO holds 0 bits.
- send_in  out  1  one-cycle pulse coincident with the last sample of a symbol.
- data_pt  out  16  registered modulated sample.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high (CLK, RESET).
- Reset:
  - Pointers and count go to 0, so bEmpty=1 and bFull=0.
  - data_pt=0, send_in=0, FSM=IDLE.
  - Storage contents are don't-care.
- Flags are decoded from the registered count: bFull = (count==DEPTH), bEmpty = (count==0).
- Write: on a CLK edge with wEN=1 and bFull=0, store dIn at wptr and increment wptr (wraps modulo DEPTH). A write while full is ignored, even if a pop happens in the same cycle.
- Pop condition: on a CLK edge with FSM=IDLE, rEN=1 and bEmpty=0.
  - Latch rdata = mem[rptr] and increment rptr (wraps).
  - Latch SELMod as mode.
  - Set cnt=0 and move to GEN.
  - In every other case rEN is ignored. A read while empty gives no symbol and no send_in.
- A write and a pop on the same edge are both performed; count is unchanged.
- FIFO ordering is strict first-in, first-out.
- Sine LUT: S[k] = round(32767*sin(2*pi*k/16)), k=0..15.
  - S[0..4] = 0, 12539, 23170, 30273, 32767.
  - The remaining entries follow by symmetry; S[8]=0, S[12]=-32767.
- GEN state: each edge outputs data_pt = f(mode, rdata, cnt), then cnt increments.
  - ASK: bit 1 gives S[cnt]; bit 0 gives 0.
  - FSK: bit 0 gives S[cnt]; bit 1 gives S[(2*cnt) mod 16], i.e. two carrier cycles per symbol.
  - BPSK: bit 1 gives S[cnt]; bit 0 gives -S[cnt]. No overflow can occur, since |S| <= 32767.
  - Reserved (11): 0.
- Timing (pop at edge T0):
  - Sample k is valid after edge T0+k+1.
  - At edge T0+16, data_pt=sample 15, send_in=1, and the FSM returns to IDLE.
  - At T0+17, send_in=0 and data_pt=0, unless a new pop occurs at T0+17 (in that case data_pt stays 0 that cycle too).
  - With rEN held high, symbols repeat with one idle cycle between them.
- SELMod changes during GEN have no effect on the current symbol.
- RESET asserted mid-symbol aborts it immediately: no send_in, data_pt=0, and the FIFO is emptied.

Optional Feature:
- Macro: SYNFIFO_ASK_HALF_AMP_EN.
- Defined: ASK bit 0 outputs S[cnt]>>>1 (arithmetic shift), i.e. a half-amplitude carrier. Example: sample 4 = 16383.
- Undefined: ASK bit 0 outputs 0.
- No other behaviour is affected.

Decomposition:
- Package syn_fifo_pkg contains:
  - mod_sel enum: MOD_ASK=2'b00, MOD_FSK=2'b01, MOD_PSK=2'b10, MOD_RSVD=2'b11.
  - FSM state enum: IDLE, GEN.
  - SAMPLES constant.
  - SINE_LUT constant array.
- Sub-module syn_fifo_carrier_gen: combinational sample function of (mode, bit, cnt) using the LUT.
- FIFO storage, pointers and the FSM stay in the top module.

Test Plan:
- Reset: RESET=1 mid-run -> bEmpty=1, bFull=0, data_pt=0, send_in=0 immediately (asynchronous).
- Fill: write 0,1,0,1,0,1,0,1 -> bFull=1 after the 8th write. A 9th write of 1 is ignored; 8 reads return 0,1,0,1,0,1,0,1.
- FSK (SELMod=01), pop bit 0 -> samples 0,12539,23170,30273,32767,…,0 at k=8, -32767 at k=12. send_in high only with k=15.
- FSK, pop bit 1 -> samples 0,23170,32767,23170,0,… (period 8). Exactly one send_in pulse per symbol, with one idle cycle before the next symbol.
- BPSK bit 0 -> k=4 gives -32767. ASK bit 0 -> all zeros (16383 at k=4 with SYNFIFO_ASK_HALF_AMP_EN).
- Edge cases:
  - rEN=1 while empty -> no send_in, data_pt stays 0.
  - Simultaneous write and pop at count=3 -> count stays 3.
  - SELMod changed mid-symbol -> no effect on the current symbol.

Source files
------------

// File: rtl/syn_fifo_pkg.sv
// Shared types and constants for the bit-serial modulator front end:
// modulation selects, FSM states and the 16-entry signed sine table.
package syn_fifo_pkg;

    localparam int SAMPLES = 16;
    localparam int DATA_W  = 16;

    typedef enum logic [1:0] {
        MOD_ASK  = 2'b00,
        MOD_FSK  = 2'b01,
        MOD_PSK  = 2'b10,
        MOD_RSVD = 2'b11
    } mod_sel;

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } fsm_state;

    typedef logic signed [DATA_W-1:0] sample_t;

    // round(32767 * sin(2*pi*k/16)), one full carrier period
    localparam sample_t SINE_LUT [SAMPLES] = '{
         16'sd0,      16'sd12539,  16'sd23170,  16'sd30273,
         16'sd32767,  16'sd30273,  16'sd23170,  16'sd12539,
         16'sd0,     -16'sd12539, -16'sd23170, -16'sd30273,
        -16'sd32767, -16'sd30273, -16'sd23170, -16'sd12539
    };

    function automatic sample_t sine_at(input logic [3:0] idx);
        return SINE_LUT[idx];
    endfunction

endpackage

// File: rtl/syn_fifo_carrier_gen.sv
// Combinational carrier sample for one (mode, bit, sample index) triple.
// SYNFIFO_ASK_HALF_AMP_EN makes ASK bit 0 a half-amplitude carrier instead of silence.
module syn_fifo_carrier_gen
    import syn_fifo_pkg::*;
(
    input  logic                     mode_sel_bit0_unused_guard,
    input  logic [1:0]               mode,
    input  logic                     bitVal,
    input  logic [3:0]               cnt,
    output logic signed [DATA_W-1:0] sample
);

    logic signed [DATA_W-1:0] baseSample;
    logic signed [DATA_W-1:0] dblSample;
    logic                     unusedGuard;

    assign unusedGuard = mode_sel_bit0_unused_guard;

    // FSK "1" runs the table at twice the rate: index (2*cnt) mod 16
    assign baseSample = sine_at(cnt);
    assign dblSample  = sine_at({cnt[2:0], 1'b0});

    always_comb begin
        sample = '0;
        case (mode)
            MOD_ASK: begin
                if (bitVal) begin
                    sample = baseSample;
                end else begin
`ifdef SYNFIFO_ASK_HALF_AMP_EN
                    sample = baseSample >>> 1;
`else
                    sample = '0;
`endif
                end
            end
            MOD_FSK: sample = bitVal ? dblSample : baseSample;
            // |S| <= 32767, so negation cannot overflow
            MOD_PSK: sample = bitVal ? baseSample : -baseSample;
            default: sample = '0;
        endcase
    end

endmodule

// File: rtl/syn_fifo.sv
// 1-bit synchronous FIFO feeding a symbol generator: each pop emits 16 carrier samples.
// Optional build macro: SYNFIFO_ASK_HALF_AMP_EN (half-amplitude ASK "0", see carrier_gen).
module syn_fifo
    import syn_fifo_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [1:0]               SELMod,
    input  logic                     wEN,
    input  logic                     rEN,
    input  logic                     dIn,
    output logic                     bFull,
    output logic                     bEmpty,
    output logic                     send_in,
    output logic signed [DATA_W-1:0] data_pt
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [3:0]     LAST_CNT = 4'(SAMPLES - 1);

    logic                     mem [DEPTH];
    logic [PTR_W-1:0]         wPtrReg;
    logic [PTR_W-1:0]         rPtrReg;
    logic [PTR_W:0]           countReg;

    fsm_state                 stateReg;
    fsm_state                 stateNext;
    logic [3:0]               cntReg;
    logic [1:0]               modeReg;
    logic                     rdataReg;

    logic                     wrEn;
    logic                     popEn;
    logic                     sendNext;
    logic signed [DATA_W-1:0] sampleNext;
    logic signed [DATA_W-1:0] carrierSample;

    assign bFull  = (countReg == FULL_CNT);
    assign bEmpty = (countReg == '0);

    // A write while full is dropped even if a pop frees a slot on the same edge
    assign wrEn  = wEN && !bFull;
    assign popEn = (stateReg == IDLE) && rEN && !bEmpty;

    // Storage has no reset so it can map onto distributed/block RAM
    always_ff @(posedge CLK) begin
        if (wrEn) begin
            mem[wPtrReg] <= dIn;
        end
    end

    syn_fifo_carrier_gen u_carrier (
        .mode_sel_bit0_unused_guard (1'b0),
        .mode                       (modeReg),
        .bitVal                     (rdataReg),
        .cnt                        (cntReg),
        .sample                     (carrierSample)
    );

    // State register plus all registered datapath/outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wPtrReg  <= '0;
            rPtrReg  <= '0;
            countReg <= '0;
            stateReg <= IDLE;
            cntReg   <= '0;
            modeReg  <= MOD_ASK;
            rdataReg <= 1'b0;
            data_pt  <= '0;
            send_in  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            data_pt  <= sampleNext;
            send_in  <= sendNext;

            if (wrEn) begin
                wPtrReg <= wPtrReg + PTR_W'(1);
            end

            case ({wrEn, popEn})
                2'b10:   countReg <= countReg + (PTR_W + 1)'(1);
                2'b01:   countReg <= countReg - (PTR_W + 1)'(1);
                default: countReg <= countReg;
            endcase

            if (popEn) begin
                rdataReg <= mem[rPtrReg];
                rPtrReg  <= rPtrReg + PTR_W'(1);
                modeReg  <= SELMod;
                cntReg   <= '0;
            end else if (stateReg == GEN) begin
                cntReg <= cntReg + 4'd1;
            end
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (popEn) stateNext = GEN;
            GEN:     if (cntReg == LAST_CNT) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are zero outside GEN, including the idle cycle between symbols
    always_comb begin
        sampleNext = '0;
        sendNext   = 1'b0;
        if (stateReg == GEN) begin
            sampleNext = carrierSample;
            sendNext   = (cntReg == LAST_CNT);
        end
    end

endmodule

// File: tb/tb_syn_fifo.sv
// Directed self-checking bench for syn_fifo: FIFO flags/order, each modulation, symbol timing.
module tb_syn_fifo;

    logic               CLK = 1'b0;
    logic               RESET;
    logic [1:0]         SELMod;
    logic               wEN;
    logic               rEN;
    logic               dIn;
    logic               bFull;
    logic               bEmpty;
    logic               send_in;
    logic signed [15:0] data_pt;

    int errors = 0;
    int checks = 0;

    logic signed [15:0] capSamp [16];
    logic               capSend [16];

    localparam logic signed [15:0] SREF [16] = '{
         16'sd0,      16'sd12539,  16'sd23170,  16'sd30273,
         16'sd32767,  16'sd30273,  16'sd23170,  16'sd12539,
         16'sd0,     -16'sd12539, -16'sd23170, -16'sd30273,
        -16'sd32767, -16'sd30273, -16'sd23170, -16'sd12539
    };

`ifdef SYNFIFO_ASK_HALF_AMP_EN
    localparam logic signed [15:0] ASK0_K4 = 16'sd16383;
    localparam logic signed [15:0] ASK0_K1 = 16'sd6269;
`else
    localparam logic signed [15:0] ASK0_K4 = 16'sd0;
    localparam logic signed [15:0] ASK0_K1 = 16'sd0;
`endif

    syn_fifo dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .SELMod  (SELMod),
        .wEN     (wEN),
        .rEN     (rEN),
        .dIn     (dIn),
        .bFull   (bFull),
        .bEmpty  (bEmpty),
        .send_in (send_in),
        .data_pt (data_pt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; wEN = 1'b0; rEN = 1'b0; dIn = 1'b0; SELMod = 2'b00;
        tick();
        tick();
        #2 RESET = 1'b0;
        tick();
    endtask

    task automatic write_bit(input logic b);
        wEN = 1'b1; dIn = b;
        tick();
        wEN = 1'b0;
    endtask

    task automatic pop_symbol(input logic [1:0] sel);
        SELMod = sel; rEN = 1'b1;
        tick();
        rEN = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            capSamp[k] = data_pt;
            capSend[k] = send_in;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bEmpty !== 1'b1) begin errors++; $display("FAIL reset_bEmpty: got %b expected 1", bEmpty); end
        checks++; if (bFull !== 1'b0) begin errors++; $display("FAIL reset_bFull: got %b expected 0", bFull); end
        checks++; if (data_pt !== 16'sd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", data_pt); end
        checks++; if (send_in !== 1'b0) begin errors++; $display("FAIL reset_send: got %b expected 0", send_in); end
        $display("test_reset: bEmpty=%b bFull=%b data_pt=%0d send_in=%b", bEmpty, bFull, data_pt, send_in);
    endtask

    task automatic test_fill();
        logic signed [15:0] exp4;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wEN = 1'b1; dIn = i[0];
            tick();
            if (i == 6) begin
                checks++; if (bFull !== 1'b0) begin errors++; $display("FAIL fill_not_full7: got %b expected 0", bFull); end
            end
        end
        wEN = 1'b0;
        checks++; if (bFull !== 1'b1) begin errors++; $display("FAIL fill_full8: got %b expected 1", bFull); end
        write_bit(1'b1);
        checks++; if (bFull !== 1'b1) begin errors++; $display("FAIL fill_full9: got %b expected 1", bFull); end
        for (int i = 0; i < 8; i++) begin
            pop_symbol(2'b10);
            exp4 = i[0] ? 16'sd32767 : -16'sd32767;
            checks++;
            if (capSamp[4] !== exp4) begin
                errors++; $display("FAIL fill_order%0d: got %0d expected %0d", i, capSamp[4], exp4);
            end
            $display("test_fill: read %0d sample4=%0d", i, capSamp[4]);
        end
        checks++; if (bEmpty !== 1'b1) begin errors++; $display("FAIL fill_empty: got %b expected 1", bEmpty); end
    endtask

    task automatic test_fsk0();
        do_reset();
        write_bit(1'b0);
        pop_symbol(2'b01);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (capSamp[k] !== SREF[k]) begin
                errors++; $display("FAIL fsk0_sample%0d: got %0d expected %0d", k, capSamp[k], SREF[k]);
            end
            checks++;
            if (capSend[k] !== (k == 15)) begin
                errors++; $display("FAIL fsk0_send%0d: got %b expected %b", k, capSend[k], (k == 15));
            end
        end
        tick();
        checks++; if (send_in !== 1'b0) begin errors++; $display("FAIL fsk0_send_after: got %b expected 0", send_in); end
        checks++; if (data_pt !== 16'sd0) begin errors++; $display("FAIL fsk0_data_after: got %0d expected 0", data_pt); end
        $display("test_fsk0: k8=%0d k12=%0d", capSamp[8], capSamp[12]);
    endtask

    task automatic test_back_to_back();
        int pulses;
        int firstAt;
        int secondAt;
        logic signed [15:0] expS;
        do_reset();
        write_bit(1'b1);
        write_bit(1'b1);
        SELMod = 2'b01; rEN = 1'b1;
        pulses = 0; firstAt = -1; secondAt = -1;
        // Cycle 1 is the first pop edge; sample k lands after cycle k+2
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (send_in === 1'b1) begin
                pulses++;
                if (firstAt < 0) firstAt = i; else if (secondAt < 0) secondAt = i;
            end
            if (i >= 2 && i <= 17) begin
                expS = SREF[(2 * (i - 2)) % 16];
                checks++;
                if (data_pt !== expS) begin
                    errors++; $display("FAIL fsk1_sample%0d: got %0d expected %0d", i - 2, data_pt, expS);
                end
            end
            if (i == 18) begin
                checks++;
                if (data_pt !== 16'sd0) begin errors++; $display("FAIL b2b_idle_data: got %0d expected 0", data_pt); end
            end
        end
        rEN = 1'b0;
        checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
        checks++; if (firstAt != 17) begin errors++; $display("FAIL b2b_first: got %0d expected 17", firstAt); end
        checks++; if (secondAt != 34) begin errors++; $display("FAIL b2b_second: got %0d expected 34", secondAt); end
        $display("test_back_to_back: pulses=%0d at %0d and %0d", pulses, firstAt, secondAt);
    endtask

    task automatic test_bpsk_ask();
        do_reset();
        write_bit(1'b0);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        pop_symbol(2'b10);
        checks++; if (capSamp[4] !== -16'sd32767) begin errors++; $display("FAIL bpsk0_k4: got %0d expected -32767", capSamp[4]); end
        checks++; if (capSamp[12] !== 16'sd32767) begin errors++; $display("FAIL bpsk0_k12: got %0d expected 32767", capSamp[12]); end
        pop_symbol(2'b00);
        checks++; if (capSamp[4] !== ASK0_K4) begin errors++; $display("FAIL ask0_k4: got %0d expected %0d", capSamp[4], ASK0_K4); end
        checks++; if (capSamp[1] !== ASK0_K1) begin errors++; $display("FAIL ask0_k1: got %0d expected %0d", capSamp[1], ASK0_K1); end
        pop_symbol(2'b00);
        checks++; if (capSamp[4] !== 16'sd32767) begin errors++; $display("FAIL ask1_k4: got %0d expected 32767", capSamp[4]); end
        pop_symbol(2'b11);
        checks++; if (capSamp[4] !== 16'sd0) begin errors++; $display("FAIL rsvd_k4: got %0d expected 0", capSamp[4]); end
        checks++; if (capSend[15] !== 1'b1) begin errors++; $display("FAIL rsvd_send: got %b expected 1", capSend[15]); end
        $display("test_bpsk_ask: done, bEmpty=%b", bEmpty);
    endtask

    task automatic test_empty_read();
        int sends;
        int nonZero;
        sends = 0; nonZero = 0;
        rEN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (send_in !== 1'b0) sends++;
            if (data_pt !== 16'sd0) nonZero++;
        end
        rEN = 1'b0;
        checks++; if (sends != 0) begin errors++; $display("FAIL empty_send: got %0d expected 0", sends); end
        checks++; if (nonZero != 0) begin errors++; $display("FAIL empty_data: got %0d expected 0", nonZero); end
        checks++; if (bEmpty !== 1'b1) begin errors++; $display("FAIL empty_flag: got %b expected 1", bEmpty); end
        $display("test_empty_read: sends=%0d nonzero=%0d", sends, nonZero);
    endtask

    task automatic test_simul();
        do_reset();
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        wEN = 1'b1; dIn = 1'b0; rEN = 1'b1; SELMod = 2'b10;
        tick();
        wEN = 1'b0; rEN = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            capSamp[k] = data_pt;
        end
        checks++; if (capSamp[4] !== 16'sd32767) begin errors++; $display("FAIL simul_bit: got %0d expected 32767", capSamp[4]); end
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        checks++; if (bFull !== 1'b0) begin errors++; $display("FAIL simul_count7: got %b expected 0", bFull); end
        write_bit(1'b1);
        checks++; if (bFull !== 1'b1) begin errors++; $display("FAIL simul_count8: got %b expected 1", bFull); end
        $display("test_simul: bFull=%b", bFull);
    endtask

    task automatic test_selmod_change();
        do_reset();
        write_bit(1'b0);
        SELMod = 2'b10; rEN = 1'b1;
        tick();
        rEN = 1'b0; SELMod = 2'b00;
        for (int k = 0; k < 16; k++) begin
            tick();
            capSamp[k] = data_pt;
        end
        checks++; if (capSamp[4] !== -16'sd32767) begin errors++; $display("FAIL selmod_k4: got %0d expected -32767", capSamp[4]); end
        checks++; if (capSamp[14] !== 16'sd23170) begin errors++; $display("FAIL selmod_k14: got %0d expected 23170", capSamp[14]); end
        $display("test_selmod_change: k4=%0d k14=%0d", capSamp[4], capSamp[14]);
    endtask

    task automatic test_reset_mid();
        int sends;
        do_reset();
        write_bit(1'b1);
        write_bit(1'b1);
        SELMod = 2'b10; rEN = 1'b1;
        tick();
        rEN = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checks++; if (data_pt !== 16'sd32767) begin errors++; $display("FAIL mid_pre: got %0d expected 32767", data_pt); end
        #2 RESET = 1'b1;
        #1;
        checks++; if (data_pt !== 16'sd0) begin errors++; $display("FAIL mid_data: got %0d expected 0", data_pt); end
        checks++; if (send_in !== 1'b0) begin errors++; $display("FAIL mid_send: got %b expected 0", send_in); end
        checks++; if (bEmpty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b expected 1", bEmpty); end
        checks++; if (bFull !== 1'b0) begin errors++; $display("FAIL mid_full: got %b expected 0", bFull); end
        #2 RESET = 1'b0;
        sends = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (send_in !== 1'b0) sends++;
        end
        checks++; if (sends != 0) begin errors++; $display("FAIL mid_abort: got %0d expected 0", sends); end
        $display("test_reset_mid: sends after reset=%0d", sends);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_fsk0();
        test_back_to_back();
        test_bpsk_ask();
        test_empty_read();
        test_simul();
        test_selmod_change();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
